game_sequencer: RTL and testbench



---
 rtl/object_package.sv | 5 +
 rtl/game_sequencer_if.sv | 27 ++
 rtl/game_sequencer.sv | 177 +++++++++++++++++
 tb/tb_game_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/object_package.sv
// Fixed-point format shared by the ball datapath and its controllers.
package object_package;
    localparam int WIDTH = 16;
    localparam int FBITS = 4;
endpackage

// File: rtl/game_sequencer_if.sv
// Signal bundle between frame timing / ball positions and the round sequencer.
interface game_sequencer_if #(
    parameter int SCORE_W = 4
);
    logic                               frame_tick;
    logic                               start;
    logic                               absorb_req;
    logic [object_package::WIDTH-1:0]   ball1_x;
    logic [object_package::WIDTH-1:0]   ball2_x;
    logic                               ball1_xs;
    logic                               ball2_xs;
    logic                               ball_en;
    logic                               absorb;
    logic [SCORE_W-1:0]                 score_l;
    logic [SCORE_W-1:0]                 score_r;
    logic                               gameover;
    logic [2:0]                         state;

    modport master (
        output frame_tick, start, absorb_req, ball1_x, ball2_x, ball1_xs, ball2_xs,
        input  ball_en, absorb, score_l, score_r, gameover, state
    );
    modport slave (
        input  frame_tick, start, absorb_req, ball1_x, ball2_x, ball1_xs, ball2_xs,
        output ball_en, absorb, score_l, score_r, gameover, state
    );
endinterface

// File: rtl/game_sequencer.sv
// Round controller: serve countdown, play/game-over phases, scoring and
// rationing of the right-player absorb power-up.
module game_sequencer #(
    parameter int SERVE_FRAMES    = 60,
    parameter int WIN_SCORE       = 7,
    parameter int SCORE_W         = 4,
    parameter int ABSORB_FRAMES   = 120,
    parameter int COOLDOWN_FRAMES = 300
) (
    input  logic            clk,
    input  logic            rst_n,
    game_sequencer_if.slave bus
);
    localparam int WIDTH = object_package::WIDTH;
    localparam int FBITS = object_package::FBITS;
    localparam int SCW   = $clog2(SERVE_FRAMES + 1);
    localparam int AMAX  = (ABSORB_FRAMES > COOLDOWN_FRAMES) ? ABSORB_FRAMES : COOLDOWN_FRAMES;
    localparam int ACW   = $clog2(AMAX + 1);

    localparam logic [WIDTH-1:0]   X_EXIT = WIDTH'(640 << FBITS);
    localparam logic [SCORE_W:0]   WIN_X  = (SCORE_W + 1)'(WIN_SCORE);
    localparam logic [SCW-1:0]     SRV_LAST = SCW'(SERVE_FRAMES - 1);
    localparam logic [ACW-1:0]     ACT_LAST = ACW'(ABSORB_FRAMES - 1);
    localparam logic [ACW-1:0]     COOL_LAST = ACW'(COOLDOWN_FRAMES - 1);

    typedef enum logic [2:0] {S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_OVER = 3'd3} state_t;
    typedef enum logic [1:0] {A_READY = 2'd0, A_ACTIVE = 2'd1, A_COOL = 2'd2} ab_state_t;

    state_t             r_state, w_state_nx;
    ab_state_t          r_ab, w_ab_nx;
    logic               r_start_q;
    logic [SCW-1:0]     r_srv_cnt, w_srv_cnt_nx;
    logic [ACW-1:0]     r_ab_cnt, w_ab_cnt_nx;
    logic [SCORE_W-1:0] r_score_l, r_score_r, w_score_l_nx, w_score_r_nx;
    logic               r_ball_en, w_ball_en_nx;
    logic               r_absorb, r_gameover;

    logic               w_start_rise, w_exit1, w_exit2, w_any_exit, w_play_ok;
    logic [1:0]         w_inc_l, w_inc_r;
    logic [SCORE_W:0]   w_sum_l, w_sum_r;
    logic [SCORE_W-1:0] w_new_l, w_new_r;

    assign w_start_rise = bus.start & ~r_start_q;
    assign w_exit1      = bus.ball1_x > X_EXIT;
    assign w_exit2      = bus.ball2_x > X_EXIT;
    assign w_any_exit   = w_exit1 | w_exit2;

    // xs=0 means the ball left through the right edge, which scores for the left player.
    assign w_inc_l = {1'b0, w_exit1 & ~bus.ball1_xs} + {1'b0, w_exit2 & ~bus.ball2_xs};
    assign w_inc_r = {1'b0, w_exit1 &  bus.ball1_xs} + {1'b0, w_exit2 &  bus.ball2_xs};
    assign w_sum_l = {1'b0, r_score_l} + (SCORE_W + 1)'(w_inc_l);
    assign w_sum_r = {1'b0, r_score_r} + (SCORE_W + 1)'(w_inc_r);
    assign w_new_l = (w_sum_l >= WIN_X) ? SCORE_W'(WIN_SCORE) : w_sum_l[SCORE_W-1:0];
    assign w_new_r = (w_sum_r >= WIN_X) ? SCORE_W'(WIN_SCORE) : w_sum_r[SCORE_W-1:0];

    always_comb begin
        w_state_nx   = r_state;
        w_srv_cnt_nx = r_srv_cnt;
        w_score_l_nx = r_score_l;
        w_score_r_nx = r_score_r;
        w_ball_en_nx = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_rise) begin
                    w_state_nx   = S_SERVE;
                    w_srv_cnt_nx = '0;
                    w_score_l_nx = '0;
                    w_score_r_nx = '0;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    if (r_srv_cnt == SRV_LAST) begin
                        w_srv_cnt_nx = '0;
                        w_state_nx   = S_PLAY;
                    end else begin
                        w_srv_cnt_nx = r_srv_cnt + SCW'(1);
                    end
                end
            end
            S_PLAY: begin
                // An exiting ball is not moved: the serve pause lets the ball
                // re-centre on its first PLAY move, so each exit counts once.
                if (bus.frame_tick) begin
                    if (w_any_exit) begin
                        w_score_l_nx = w_new_l;
                        w_score_r_nx = w_new_r;
                        w_srv_cnt_nx = '0;
                        w_state_nx   = ({1'b0, w_new_l} >= WIN_X || {1'b0, w_new_r} >= WIN_X)
                                       ? S_OVER : S_SERVE;
                    end else begin
                        w_ball_en_nx = 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign w_play_ok = (r_state == S_PLAY) && (w_state_nx == S_PLAY);

    always_comb begin
        w_ab_nx     = r_ab;
        w_ab_cnt_nx = r_ab_cnt;
        case (r_ab)
            A_READY: begin
                w_ab_cnt_nx = '0;
                if (bus.absorb_req && w_play_ok) w_ab_nx = A_ACTIVE;
            end
            A_ACTIVE: begin
                if (!bus.absorb_req || !w_play_ok) begin
                    w_ab_nx     = A_COOL;
                    w_ab_cnt_nx = '0;
                end else if (bus.frame_tick) begin
                    if (r_ab_cnt == ACT_LAST) begin
                        w_ab_nx     = A_COOL;
                        w_ab_cnt_nx = '0;
                    end else begin
                        w_ab_cnt_nx = r_ab_cnt + ACW'(1);
                    end
                end
            end
            A_COOL: begin
                if (bus.frame_tick) begin
                    if (r_ab_cnt == COOL_LAST) begin
                        w_ab_nx     = A_READY;
                        w_ab_cnt_nx = '0;
                    end else begin
                        w_ab_cnt_nx = r_ab_cnt + ACW'(1);
                    end
                end
            end
            default: begin
                w_ab_nx     = A_READY;
                w_ab_cnt_nx = '0;
            end
        endcase
        // A finished game hands the next one a fresh power-up.
        if (w_state_nx == S_OVER && r_state != S_OVER) begin
            w_ab_nx     = A_READY;
            w_ab_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ab       <= A_READY;
            r_start_q  <= 1'b0;
            r_srv_cnt  <= '0;
            r_ab_cnt   <= '0;
            r_score_l  <= '0;
            r_score_r  <= '0;
            r_ball_en  <= 1'b0;
            r_absorb   <= 1'b0;
            r_gameover <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ab       <= w_ab_nx;
            r_start_q  <= bus.start;
            r_srv_cnt  <= w_srv_cnt_nx;
            r_ab_cnt   <= w_ab_cnt_nx;
            r_score_l  <= w_score_l_nx;
            r_score_r  <= w_score_r_nx;
            r_ball_en  <= w_ball_en_nx;
            r_absorb   <= (w_ab_nx == A_ACTIVE);
            r_gameover <= (w_state_nx == S_OVER);
        end
    end

    assign bus.ball_en  = r_ball_en;
    assign bus.absorb   = r_absorb;
    assign bus.score_l  = r_score_l;
    assign bus.score_r  = r_score_r;
    assign bus.gameover = r_gameover;
    assign bus.state    = r_state;
endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: each driven cycle queues its expected outputs.
module tb_game_sequencer;
    localparam int WIDTH = object_package::WIDTH;
    localparam int FBITS = object_package::FBITS;
    localparam int SF = 4, WS = 7, SW = 4, AF = 3, CF = 5;
    localparam logic [WIDTH-1:0] X_EDGE = WIDTH'(640 << FBITS);
    localparam logic [WIDTH-1:0] X_OUT  = WIDTH'(641 << FBITS);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_sequencer_if #(.SCORE_W(SW)) bus();

    game_sequencer #(
        .SERVE_FRAMES(SF), .WIN_SCORE(WS), .SCORE_W(SW),
        .ABSORB_FRAMES(AF), .COOLDOWN_FRAMES(CF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct { string tag; logic [13:0] val; } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_fail = 0;
    int e_st = 0, e_sl = 0, e_sr = 0, e_go = 0, e_ab = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] obs();
        return {bus.state, bus.ball_en, bus.absorb, bus.score_l, bus.score_r, bus.gameover};
    endfunction

    // Packed as {state, ball_en, absorb, score_l, score_r, gameover}.
    task automatic step(input string tag, input bit ft, input bit en);
        exp_t e;
        bus.frame_tick = ft;
        e.tag = tag;
        e.val = {3'(e_st), en, 1'(e_ab), 4'(e_sl), 4'(e_sr), 1'(e_go)};
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        e = sb.pop_front();
        chk(e.tag, {18'd0, obs()}, {18'd0, e.val});
    endtask

    task automatic serve();
        for (int i = 1; i <= SF; i++) begin
            if (i == SF) e_st = 2;
            step("serve_tick", 1'b1, 1'b0);
            step("serve_gap", 1'b0, 1'b0);
        end
    endtask

    task automatic play_tick(input string tag);
        step(tag, 1'b1, 1'b1);
        step({tag, "_gap"}, 1'b0, 1'b0);
    endtask

    task automatic exit_tick(input string tag, input logic [WIDTH-1:0] x1, input bit s1,
                             input logic [WIDTH-1:0] x2, input bit s2, input int dl, input int dr);
        bus.ball1_x = x1; bus.ball1_xs = s1;
        bus.ball2_x = x2; bus.ball2_xs = s2;
        e_sl = (e_sl + dl > WS) ? WS : e_sl + dl;
        e_sr = (e_sr + dr > WS) ? WS : e_sr + dr;
        e_st = (e_sl >= WS || e_sr >= WS) ? 3 : 1;
        e_go = (e_st == 3) ? 1 : 0;
        step(tag, 1'b1, 1'b0);
        bus.ball1_x = '0; bus.ball1_xs = 1'b0;
        bus.ball2_x = '0; bus.ball2_xs = 1'b0;
        step({tag, "_gap"}, 1'b0, 1'b0);
    endtask

    initial begin
        bus.frame_tick = 1'b0; bus.start = 1'b0; bus.absorb_req = 1'b0;
        bus.ball1_x = '0; bus.ball2_x = '0; bus.ball1_xs = 1'b0; bus.ball2_xs = 1'b0;
        #12;
        chk("reset", {18'd0, obs()}, 32'd0);
        rst_n = 1'b1;
        step("tick_after_release", 1'b1, 1'b0);
        step("idle_tick", 1'b1, 1'b0);

        bus.start = 1'b1; e_st = 1;
        step("start", 1'b0, 1'b0);
        bus.start = 1'b0;
        serve();
        play_tick("first_en");
        bus.ball1_x = X_EDGE;
        play_tick("x_at_edge");
        bus.ball1_x = '0;

        exit_tick("exit_right", X_OUT, 1'b0, '0, 1'b0, 1, 0);
        bus.start = 1'b1;
        step("start_ign_serve", 1'b0, 1'b0);
        bus.start = 1'b0;
        serve();
        bus.start = 1'b1;
        step("start_ign_play", 1'b0, 1'b0);
        bus.start = 1'b0;
        exit_tick("exit_wrap", X_OUT, 1'b1, '0, 1'b0, 0, 1);
        serve();
        exit_tick("exit_split", X_OUT, 1'b0, X_OUT, 1'b1, 1, 1);
        serve();
        for (int i = 0; i < 4; i++) begin
            exit_tick("exit_run", '0, 1'b0, X_OUT, 1'b0, 1, 0);
            serve();
        end
        exit_tick("double_win", X_OUT, 1'b0, X_OUT, 1'b0, 2, 0);
        step("over_hold", 1'b1, 1'b0);

        bus.start = 1'b1;
        e_sl = 0; e_sr = 0; e_st = 1; e_go = 0;
        step("restart", 1'b0, 1'b0);
        bus.start = 1'b0;
        serve();

        bus.absorb_req = 1'b1; e_ab = 1;
        step("ab_on", 1'b0, 1'b0);
        play_tick("ab_t1");
        play_tick("ab_t2");
        e_ab = 0;
        play_tick("ab_expire");
        bus.absorb_req = 1'b0;
        step("ab_release", 1'b0, 1'b0);
        bus.absorb_req = 1'b1;
        step("ab_cool_press", 1'b0, 1'b0);
        for (int i = 1; i < CF; i++) play_tick("cool_tick");
        step("cool_last", 1'b1, 1'b1);
        e_ab = 1;
        step("ab_again", 1'b0, 1'b0);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {18'd0, obs()}, 32'd0);
        rst_n = 1'b1;
        bus.absorb_req = 1'b0;
        e_st = 0; e_sl = 0; e_sr = 0; e_go = 0; e_ab = 0;
        for (int i = 0; i < 3; i++) begin
            step("post_rst_tick", 1'b1, 1'b0);
            step("post_rst_gap", 1'b0, 1'b0);
        end
        bus.start = 1'b1; e_st = 1;
        step("start_after_rst", 1'b0, 1'b0);
        bus.start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
